mem_port_arbiter: RTL

- Shares the single 24-bit-address / 16-bit-data memory port between two masters.
- Port 0 is the CPU core (instruction fetch, load, store).
- Port 1 is the auxiliary master (program loader / debug).
- Serialises accesses with round-robin arbitration, drives the memory interface for a parameterised fixed read latency, and returns read data to the winning master.

---
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter for a single memory port with a fixed read latency.
// One access in flight at a time; read data is registered back to the winning master.
module mem_port_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_we,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_LATENCY - 1);

    state_t     state, state_nxt;
    logic       last_gnt;
    logic       win_id;
    logic       we_q;
    logic [3:0] lat_cnt;
    logic       arb_open;
    logic       any_req;
    logic       pick;

    // RESP doubles as an arbitration slot so back-to-back accesses lose no cycle.
    assign arb_open = (state == IDLE) || (state == RESP);
    assign any_req  = m0_req || m1_req;
    assign pick     = (m0_req && m1_req) ? ~last_gnt : m1_req;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RESP: state_nxt = any_req ? ACCESS : IDLE;
            ACCESS: begin
                if (we_q)                  state_nxt = IDLE;
                else if (MEM_LATENCY == 1) state_nxt = RESP;
                else                       state_nxt = WAIT;
            end
            WAIT:    state_nxt = (lat_cnt == 4'd1) ? RESP : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    assign m0_gnt = (state == ACCESS) && !win_id;
    assign m1_gnt = (state == ACCESS) &&  win_id;
    assign mem_we = (state == ACCESS) &&  we_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            win_id    <= 1'b0;
            we_q      <= 1'b0;
            lat_cnt   <= 4'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;

            if (arb_open && any_req) begin
                win_id    <= pick;
                last_gnt  <= pick;
                we_q      <= pick ? m1_we    : m0_we;
                mem_addr  <= pick ? m1_addr  : m0_addr;
                mem_wdata <= pick ? m1_wdata : m0_wdata;
            end

            if (state == ACCESS)    lat_cnt <= WAIT_INIT;
            else if (state == WAIT) lat_cnt <= lat_cnt - 4'd1;

            // win_id still names the finishing access here; any new winner lands next cycle.
            if (state == RESP) begin
                if (win_id) begin
                    m1_rdata  <= mem_rdata;
                    m1_rvalid <= 1'b1;
                end else begin
                    m0_rdata  <= mem_rdata;
                    m0_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule
